// File: rtl/spi_txn_loader.sv
// spi_txn_loader: buffers (addr,data) pairs and, on go, loads them into the SPI
// controller over APB: address regs 0x00+k, data regs 0x10+k, then control 0x20.
// Ports:
//   pclk, prst          clock, async active-high reset
//   in_valid/in_ready   pair source handshake; in_addr/in_data pair fields
//   go                  start a burst; busy/done/err burst status
//   paddr/pwdata/penable/pwr_rd/pready  APB write master toward the controller
module spi_txn_loader #(
   parameter int WIDTH   = 8,
   parameter int MAX_TXN = 8,
   parameter int TIMEOUT = 255
) (
   input  logic             pclk,
   input  logic             prst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_addr,
   input  logic [WIDTH-1:0] in_data,
   input  logic             go,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] paddr,
   output logic [WIDTH-1:0] pwdata,
   output logic             penable,
   output logic             pwr_rd,
   input  logic             pready
);
   localparam int KW = (MAX_TXN > 1) ? $clog2(MAX_TXN) : 1;
   localparam int CW = $clog2(MAX_TXN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CTRL, S_GAP, S_END} state_t;

   state_t           r_state, w_next, r_after, w_after;
   logic [CW-1:0]    r_count, w_cm1;
   logic [KW-1:0]    r_k, w_k, w_widx;
   logic [TW-1:0]    r_to;
   logic             r_err;
   logic [WIDTH-1:0] r_addr_mem [MAX_TXN];
   logic [WIDTH-1:0] r_data_mem [MAX_TXN];
   logic             w_access, w_acc, w_start, w_tmo, w_last;

   assign w_access = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CTRL);
   assign busy     = w_access || (r_state == S_GAP);
   assign in_ready = !busy && (r_count < CW'(MAX_TXN));
   assign w_acc    = in_valid && in_ready;
   // an entry accepted in the same cycle as go counts toward this burst
   assign w_start  = (r_state == S_IDLE) && go && ((r_count != '0) || w_acc);
   assign w_tmo    = w_access && !pready && (r_to == TW'(TIMEOUT - 1));
   assign w_cm1    = r_count - 1'b1;
   assign w_last   = (r_k == w_cm1[KW-1:0]);
   // S_END clears count in the same cycle in_ready reopens, so a pair taken then goes to slot 0
   assign w_widx   = (r_state == S_END) ? '0 : r_count[KW-1:0];

   assign penable = w_access;
   assign pwr_rd  = w_access;
   assign paddr   = (r_state == S_ADDR) ? WIDTH'(r_k) :
                    (r_state == S_DATA) ? WIDTH'(16) + WIDTH'(r_k) :
                    (r_state == S_CTRL) ? WIDTH'(32) : '0;
   assign pwdata  = (r_state == S_ADDR) ? r_addr_mem[r_k] :
                    (r_state == S_DATA) ? r_data_mem[r_k] :
                    (r_state == S_CTRL) ? WIDTH'({w_cm1[2:0], 1'b1}) : '0;
   assign done    = (r_state == S_END);
   assign err     = r_err;

   always_comb begin
      w_next  = r_state;
      w_after = r_after;
      w_k     = r_k;
      case (r_state)
         S_IDLE: begin
            w_next = w_start ? S_ADDR : S_IDLE;
            w_k    = '0;
         end
         S_ADDR, S_DATA, S_CTRL: begin
            if (w_tmo) begin
               w_next = S_IDLE;
               w_k    = '0;
            end else if (pready) begin
               w_next  = S_GAP;
               w_after = (r_state == S_CTRL) ? S_END :
                         !w_last             ? r_state :
                         (r_state == S_ADDR) ? S_DATA : S_CTRL;
               w_k     = (w_last || r_state == S_CTRL) ? '0 : r_k + 1'b1;
            end
         end
         S_GAP:   w_next = r_after;
         S_END:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         r_state <= S_IDLE;
         r_after <= S_IDLE;
         r_k     <= '0;
      end else begin
         r_state <= w_next;
         r_after <= w_after;
         r_k     <= w_k;
      end
   end

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         r_count <= '0;
         r_to    <= '0;
         r_err   <= 1'b0;
      end else begin
         if (r_state == S_END)
            r_count <= CW'(w_acc);
         else if (w_tmo)
            r_count <= '0;
         else if (w_acc)
            r_count <= r_count + 1'b1;
         r_to  <= (w_access && !pready && !w_tmo) ? r_to + 1'b1 : '0;
         r_err <= w_tmo;
      end
   end

   always_ff @(posedge pclk) begin
      if (w_acc) begin
         r_addr_mem[w_widx] <= in_addr;
         r_data_mem[w_widx] <= in_data;
      end
   end
endmodule

// File: tb/tb_spi_txn_loader.sv
// tb_spi_txn_loader: scoreboard bench for spi_txn_loader (APB write sequence, timing, timeout, reset)
module tb_spi_txn_loader;
   localparam int TIMEOUT = 255;

   logic       pclk = 1'b0, prst = 1'b1;
   logic       in_valid = 1'b0, go = 1'b0;
   logic [7:0] in_addr = '0, in_data = '0;
   logic       in_ready, busy, done, err, penable, pwr_rd, pready;
   logic [7:0] paddr, pwdata;

   spi_txn_loader #(.WIDTH(8), .MAX_TXN(8), .TIMEOUT(TIMEOUT)) dut (
      .pclk(pclk), .prst(prst), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .go(go), .busy(busy), .done(done),
      .err(err), .paddr(paddr), .pwdata(pwdata), .penable(penable),
      .pwr_rd(pwr_rd), .pready(pready)
   );

   always #5 pclk = ~pclk;

   typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
   wr_t        sb[$];
   logic [7:0] ma[8], md[8];
   int         n = 0;
   int         n_chk = 0, n_fail = 0, done_cnt = 0;
   int         mode = 0;
   int         wcnt = 0, hold = 0;
   bit         gap_chk = 0;

   assign pready = (mode == 0) ? 1'b1 : (mode == 1) ? (penable && wcnt == 3) : 1'b0;

   always @(posedge pclk) wcnt <= (penable && !pready) ? wcnt + 1 : 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge pclk) begin
      if (prst) begin
         gap_chk = 0;
         hold = 0;
      end else begin
         if (done) done_cnt++;
         if (gap_chk) check("gap", {penable, pwr_rd, paddr, pwdata}, 0);
         gap_chk = 0;
         if (penable) begin
            hold++;
            if (sb.size() == 0) check("unexpected_access", penable, 0);
            else begin
               check("paddr", paddr, sb[0].a);
               check("pwdata", pwdata, sb[0].d);
               check("pwr_rd", pwr_rd, 1);
               if (pready) begin
                  if (mode == 1) check("hold", hold, 4);
                  void'(sb.pop_front());
                  gap_chk = 1;
                  hold = 0;
               end
            end
         end
      end
   end

   task automatic push(input logic [7:0] a, input logic [7:0] d);
      in_valid = 1; in_addr = a; in_data = d;
      if (n < 8) begin ma[n] = a; md[n] = d; n++; end
      @(posedge pclk); #1 in_valid = 0;
   endtask

   task automatic run_burst(input bit with_push, input logic [7:0] a, input logic [7:0] d,
                            input int exp_busy, input bit exp_err);
      int nb;
      if (with_push) begin
         in_valid = 1; in_addr = a; in_data = d;
         ma[n] = a; md[n] = d; n++;
      end
      for (int k = 0; k < n; k++) sb.push_back('{8'(k), ma[k]});
      for (int k = 0; k < n; k++) sb.push_back('{8'(16 + k), md[k]});
      sb.push_back('{8'h20, 8'(((n - 1) << 1) | 1)});
      go = 1;
      @(posedge pclk); #1 go = 0; in_valid = 0;
      check("busy_rise", busy, 1);
      nb = 0;
      while (busy && nb < 5000) begin nb++; @(posedge pclk); #1; end
      check("busy_len", nb, exp_busy);
      check("done", done, !exp_err);
      check("err", err, exp_err);
      check("penable_end", penable, 0);
      @(posedge pclk); #1;
      check("done_pulse", done, 0);
      check("err_pulse", err, 0);
      check("ready_after", in_ready, 1);
      if (!exp_err) check("sb_empty", sb.size(), 0);
      sb.delete();
      n = 0;
   endtask

   initial begin
      int t;
      #2 check("reset_outs", {paddr, pwdata, penable, pwr_rd, busy, done, err}, 0);
      repeat (3) @(posedge pclk);
      #1 prst = 0;
      check("reset_ready", in_ready, 1);
      check("reset_outs2", {paddr, pwdata, penable, pwr_rd, busy, done, err}, 0);

      for (int k = 0; k < 8; k++) push(8'(8'hD3 + k), 8'(8'h12 + k));
      check("full_ready", in_ready, 0);
      push(8'hEE, 8'hEE);
      run_burst(0, 0, 0, 34, 0);

      go = 1; @(posedge pclk); #1 go = 0;
      repeat (4) begin
         check("empty_go_busy", busy, 0);
         @(posedge pclk); #1;
      end
      check("empty_go_done", done_cnt, 1);

      push(8'h01, 8'h81);
      push(8'h02, 8'h82);
      run_burst(1, 8'h03, 8'h83, 14, 0);

      mode = 1;
      for (int k = 0; k < 4; k++) push(8'(8'h40 + k), 8'(8'h60 + k));
      run_burst(0, 0, 0, 45, 0);

      mode = 2;
      push(8'h11, 8'h22);
      push(8'h33, 8'h44);
      run_burst(0, 0, 0, TIMEOUT, 1);

      mode = 0;
      push(8'hAA, 8'h55);
      run_burst(0, 0, 0, 6, 0);

      mode = 1;
      for (int k = 0; k < 4; k++) push(8'(8'h70 + k), 8'(8'h90 + k));
      for (int k = 0; k < n; k++) sb.push_back('{8'(k), ma[k]});
      for (int k = 0; k < n; k++) sb.push_back('{8'(16 + k), md[k]});
      go = 1; @(posedge pclk); #1 go = 0;
      t = 0;
      while (paddr != 8'h10 && t < 200) begin t++; @(posedge pclk); #1; end
      check("reach_data", paddr, 8'h10);
      #2 prst = 1;
      #1 check("rst_outs", {paddr, pwdata, penable, pwr_rd, busy, done, err}, 0);
      check("rst_ready", in_ready, 1);
      @(posedge pclk); #1 prst = 0;
      sb.delete();
      n = 0;
      mode = 0;
      push(8'hAA, 8'h55);
      run_burst(0, 0, 0, 6, 0);

      check("done_total", done_cnt, 5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
